main_mem_ctrl: RTL and testbench
================================

// Module: main_mem_ctrl
// PURPOSE
//  Two-port arbiter and sequencer in front of the byte-wide main memory (CS/OE/WE, bidir Data).
//  Shares the RAM between instruction fetch (port 0) and load/store (port 1) using round-robin.
//  Turns each byte, half or word request into 1/2/4 single-byte RAM beats, little-endian.
//  Sits between the core's memory stage and the RAM chip; owns the RAM's only bus master.
// PARAMETERS
//  ADDR_W   32  RAM address width; beat addresses wrap modulo 2**ADDR_W
//  BYTE_W   8   RAM data width
//  WORD_W   32  requester data width (4 bytes)
// PORTS
//  clk       in   1       single clock; RAM shares it
//  rst_n     in   1       asynchronous, active-low reset
//  pN_req    in   1       N=0,1: request; held with fields stable until pN_ack
//  pN_we     in   1       1 = write, 0 = read
//  pN_size   in   2       00 byte, 01 half, 10 word, 11 treated as word
//  pN_addr   in   ADDR_W  byte address of lowest byte; no alignment required
//  pN_wdata  in   WORD_W  write data; byte i goes to addr+i
//  pN_ack    out  1       one-cycle completion pulse
//  pN_rdata  out  WORD_W  read data, valid while pN_ack=1; unused upper bytes zero
//  mem_cs    out  1       RAM chip select
//  mem_oe    out  1       RAM output enable
//  mem_we    out  1       RAM write enable
//  mem_addr  out  ADDR_W  RAM address
//  mem_data  inout BYTE_W RAM data; driven only during write beats, else 'z
// BEHAVIOUR
//  Reset: state IDLE, all mem_* and pN_ack = 0, mem_addr/pN_rdata = 0, mem_data = 'z,
//   last_grant = 1 (so port 0 wins first tie). Reset is async; it takes effect mid-transfer.
//  FSM: IDLE -> BEAT -> DONE -> IDLE.
//   IDLE: no req -> stay; else grant (one req -> that port; both -> port != last_grant),
//    latch we/size/addr/wdata, beats = 1/2/4, beat idx = 0, last_grant = winner -> BEAT.
//   BEAT: registered outputs mem_cs=1, mem_addr=addr+idx (ADDR_W wrap), mem_we=we,
//    mem_oe=!we, mem_data=wdata[8*idx+:8] if we. Write lands at RAM posedge ending the beat.
//    Read: RAM drives Data after the mid-beat negedge; controller samples mem_data at posedge
//    ending the beat into rdata byte idx. idx==beats-1 -> DONE, else idx+1.
//   DONE: all mem_* deasserted, mem_data 'z; pN_ack=1 for winner only, rdata presented -> IDLE.
//  Latency: req sampled in IDLE at edge t; beats occupy cycles t+1..t+B; ack in cycle t+B+1.
//   Word = 6 cycles req-to-ack inclusive; min one IDLE cycle between transfers.
//  Losing port keeps req asserted and is served next; no starvation (strict alternation under load).
//  mem_oe and mem_we never both 1; mem_data never driven while mem_oe=1 (no bus contention).
//  req dropped before ack: protocol violation; transfer still completes, ack still pulses.
//  Reset mid-transfer: outputs drop asynchronously, no ack, already-written bytes stay in RAM.
//  rdata bytes >= beats are 0; pN_rdata holds last value when ack=0.
// STRUCTURE
//  Shared package main_mem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum,
//   size->beat-count function, BYTE_W/WORD_W constants.
//  One sub-module: rr_arb2 (2-way round-robin, registered last_grant, grant valid in IDLE).
//  Beat counter, request latch, read-assembly register and FSM stay in main_mem_ctrl.
// TESTING
//  Bench instantiates the RAM model (small ADDR_W for the array) plus a bus-contention checker.
//  1 Reset: rst_n=0 -> mem_cs/oe/we=0, mem_data=Z, p0_ack=p1_ack=0, mem_addr=0.
//  2 p0 word write addr 0x100 wdata 0xDEADBEEF -> beats addr 0x100..0x103, data EF,BE,AD,DE,
//    mem_we=1; p0_ack one cycle in cycle t+5.
//  3 p1 word read addr 0x100 after (2) -> mem_oe=1 four beats, p1_rdata=0xDEADBEEF, ack at t+5.
//  4 p0,p1 both req from reset, both word reads -> p0 served first, p1 next; repeat tie -> p0
//    again (alternation); neither port acked twice in a row while other waits.
//  5 p1 half read addr 2**ADDR_W-1 -> beat addrs all-ones then 0; rdata[31:16]=0, ack at t+3.
//  6 rst_n low during beat 2 of word write -> mem_* drop same cycle, no ack, next req from IDLE.

Source files
------------

// File: rtl/main_mem_pkg.sv
// Shared encodings for the main-memory controller: request sizes, FSM states
// and the size-to-beat-count rule.
package main_mem_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Encoding 2'b11 is treated as a word, so it falls into the default arm.
    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: beat_count = 3'd1;
            SZ_HALF: beat_count = 3'd2;
            default: beat_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the grant is combinational and last_grant is
// updated only when the caller consumes the grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_valid,
    output logic       o_grant
);

    logic r_last;

    always_comb begin
        o_valid = |i_req;
        if (&i_req) begin
            o_grant = ~r_last;
        end else begin
            o_grant = i_req[1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_take && o_valid) begin
            r_last <= o_grant;
        end
    end

endmodule

// File: rtl/main_mem_ctrl.sv
// Round-robin two-port sequencer for a byte-wide RAM: each byte/half/word request
// becomes 1/2/4 little-endian single-byte beats on a shared CS/OE/WE bus.
module main_mem_ctrl
    import main_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [1:0]        p0_size,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [WORD_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [WORD_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [1:0]        p1_size,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [WORD_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [WORD_W-1:0] p1_rdata,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [BYTE_W-1:0] mem_data
);

    state_e              r_state, w_state_nxt;
    logic                w_gnt_valid, w_gnt, w_take;
    logic                w_sel_we;
    logic [1:0]          w_sel_size;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [WORD_W-1:0]   w_sel_wdata;

    logic                r_port, r_we;
    logic [1:0]          r_idx, r_last_idx, w_idx_inc;
    logic [ADDR_W-1:0]   r_addr, r_mem_addr, w_addr_nxt;
    logic [WORD_W-1:0]   r_wdata, r_asm, w_asm_nxt, r_rdata0, r_rdata1;
    logic                r_mem_cs, r_mem_oe, r_mem_we;
    logic                w_cs_nxt, w_oe_nxt, w_we_nxt;
    logic [BYTE_W-1:0]   r_dout, w_dout_nxt;
    logic [1:0]          r_ack, w_ack_nxt;

    assign w_take = (r_state == ST_IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   ({p1_req, p0_req}),
        .i_take  (w_take),
        .o_valid (w_gnt_valid),
        .o_grant (w_gnt)
    );

    assign w_sel_we    = w_gnt ? p1_we    : p0_we;
    assign w_sel_size  = w_gnt ? p1_size  : p0_size;
    assign w_sel_addr  = w_gnt ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_gnt ? p1_wdata : p0_wdata;
    assign w_idx_inc   = r_idx + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cs_nxt    = 1'b0;
        w_oe_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_mem_addr;
        w_dout_nxt  = r_dout;
        w_ack_nxt   = 2'b00;
        w_asm_nxt   = r_asm;
        for (int b = 0; b < 4; b++) begin
            if (!r_we && r_idx == 2'(b)) begin
                w_asm_nxt[BYTE_W*b +: BYTE_W] = mem_data;
            end
        end
        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_state_nxt = ST_BEAT;
                    w_cs_nxt    = 1'b1;
                    w_we_nxt    = w_sel_we;
                    w_oe_nxt    = !w_sel_we;
                    w_addr_nxt  = w_sel_addr;
                    w_dout_nxt  = w_sel_wdata[BYTE_W-1:0];
                end
            end
            ST_BEAT: begin
                if (r_idx == r_last_idx) begin
                    w_state_nxt       = ST_DONE;
                    w_ack_nxt[r_port] = 1'b1;
                end else begin
                    w_cs_nxt   = 1'b1;
                    w_we_nxt   = r_we;
                    w_oe_nxt   = !r_we;
                    w_addr_nxt = r_addr + ADDR_W'(w_idx_inc);
                    w_dout_nxt = BYTE_W'(r_wdata >> {w_idx_inc, 3'b000});
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_asm      <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_mem_cs   <= 1'b0;
            r_mem_oe   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_dout     <= '0;
            r_ack      <= 2'b00;
        end else begin
            r_mem_cs   <= w_cs_nxt;
            r_mem_oe   <= w_oe_nxt;
            r_mem_we   <= w_we_nxt;
            r_mem_addr <= w_addr_nxt;
            r_dout     <= w_dout_nxt;
            r_ack      <= w_ack_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_port     <= w_gnt;
                        r_we       <= w_sel_we;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_last_idx <= 2'(beat_count(w_sel_size) - 3'd1);
                        r_idx      <= '0;
                        r_asm      <= '0;
                    end
                end
                ST_BEAT: begin
                    r_asm <= w_asm_nxt;
                    if (r_idx == r_last_idx) begin
                        // The final byte is merged on the same edge that enters DONE.
                        if (!r_we && r_port) r_rdata1 <= w_asm_nxt;
                        if (!r_we && !r_port) r_rdata0 <= w_asm_nxt;
                    end else begin
                        r_idx <= w_idx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_cs   = r_mem_cs;
    assign mem_oe   = r_mem_oe;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_we ? r_dout : {BYTE_W{1'bz}};
    assign p0_ack   = r_ack[0];
    assign p1_ack   = r_ack[1];
    assign p0_rdata = r_rdata0;
    assign p1_rdata = r_rdata1;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: byte RAM model on the shared bus and a
// transaction-level reference (byte array + round-robin owner) for expected values.
module tb_main_mem_ctrl;

    localparam int ADDR_W = 32;
    localparam int RAM_N  = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we_q = 2'b00;
    logic [1:0]  size_q [2];
    logic [31:0] addr_q [2];
    logic [31:0] wdata_q [2];

    wire         p0_ack, p1_ack, mem_cs, mem_oe, mem_we;
    wire  [31:0] p0_rdata, p1_rdata, mem_addr;
    wire  [7:0]  mem_data;

    logic [7:0]  ram [RAM_N];
    logic [7:0]  ref_mem [RAM_N];
    logic        ram_drive = 1'b0;
    logic [7:0]  ram_dout = 8'h00;
    int          ref_last = 1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    main_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p0_req   (req[0]),
        .p0_we    (we_q[0]),
        .p0_size  (size_q[0]),
        .p0_addr  (addr_q[0]),
        .p0_wdata (wdata_q[0]),
        .p0_ack   (p0_ack),
        .p0_rdata (p0_rdata),
        .p1_req   (req[1]),
        .p1_we    (we_q[1]),
        .p1_size  (size_q[1]),
        .p1_addr  (addr_q[1]),
        .p1_wdata (wdata_q[1]),
        .p1_ack   (p1_ack),
        .p1_rdata (p1_rdata),
        .mem_cs   (mem_cs),
        .mem_oe   (mem_oe),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    // RAM: drives read data after the mid-beat negedge, stores writes at posedge.
    assign mem_data = ram_drive ? ram_dout : 8'bz;
    always @(clk) begin
        if (clk) begin
            ram_drive <= 1'b0;
            if (mem_cs && mem_we) ram[10'(mem_addr)] <= mem_data;
        end else begin
            ram_drive <= mem_cs & mem_oe;
            ram_dout  <= ram[10'(mem_addr)];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("oe_we_exclusive", {31'b0, mem_oe & mem_we}, 32'd0);
            check("ack_exclusive", {31'b0, p0_ack & p1_ack}, 32'd0);
        end
    end

    function automatic logic ack_of(input int p);
        return (p == 1) ? p1_ack : p0_ack;
    endfunction

    function automatic logic [31:0] rdata_of(input int p);
        return (p == 1) ? p1_rdata : p0_rdata;
    endfunction

    function automatic int nbeats(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Called #1 after the granting edge; returns #1 into the ack cycle with req dropped.
    task automatic check_txn(input int p);
        int          nb;
        logic [31:0] a, wd, exp_rd;
        logic        w;
        nb = nbeats(size_q[p]);
        a  = addr_q[p];
        wd = wdata_q[p];
        w  = we_q[p];
        exp_rd = 32'd0;
        for (int k = 0; k < nb; k++) begin
            exp_rd[8*k +: 8] = ref_mem[10'(a + 32'(k))];
        end
        for (int k = 0; k < nb; k++) begin
            check($sformatf("p%0d beat%0d cs", p, k), {31'b0, mem_cs}, 32'd1);
            check($sformatf("p%0d beat%0d addr", p, k), mem_addr, a + 32'(k));
            check($sformatf("p%0d beat%0d we", p, k), {31'b0, mem_we}, {31'b0, w});
            check($sformatf("p%0d beat%0d oe", p, k), {31'b0, mem_oe}, {31'b0, !w});
            check($sformatf("p%0d beat%0d early_ack", p, k), {31'b0, p0_ack | p1_ack}, 32'd0);
            if (w) begin
                check($sformatf("p%0d beat%0d wdata", p, k), {24'b0, mem_data}, {24'b0, wd[8*k +: 8]});
                ref_mem[10'(a + 32'(k))] = wd[8*k +: 8];
            end
            @(posedge clk); #1;
        end
        check($sformatf("p%0d ack", p), {31'b0, ack_of(p)}, 32'd1);
        check($sformatf("p%0d other_ack", p), {31'b0, ack_of(1 - p)}, 32'd0);
        check($sformatf("p%0d done_cs", p), {29'b0, mem_cs, mem_oe, mem_we}, 32'd0);
        if (!w) check($sformatf("p%0d rdata", p), rdata_of(p), exp_rd);
        req[p] = 1'b0;
        ref_last = p;
    endtask

    task automatic load_port(input int p, input logic w, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd);
        we_q[p]    = w;
        size_q[p]  = sz;
        addr_q[p]  = a;
        wdata_q[p] = wd;
        req[p]     = 1'b1;
    endtask

    task automatic run_single(input int p, input logic w, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        load_port(p, w, sz, a, wd);
        @(posedge clk); #1;
        check_txn(p);
        @(posedge clk); #1;
        check("ack_one_cycle", {31'b0, p0_ack | p1_ack}, 32'd0);
    endtask

    task automatic run_pair(input logic w0, input logic [1:0] s0, input logic [31:0] a0, input logic [31:0] d0,
                            input logic w1, input logic [1:0] s1, input logic [31:0] a1, input logic [31:0] d1);
        int winner;
        @(negedge clk);
        load_port(0, w0, s0, a0, d0);
        load_port(1, w1, s1, a1, d1);
        winner = 1 - ref_last;
        @(posedge clk); #1;
        check_txn(winner);
        @(posedge clk); #1;
        check("gap_cs", {31'b0, mem_cs}, 32'd0);
        check("gap_ack", {31'b0, p0_ack | p1_ack}, 32'd0);
        @(posedge clk); #1;
        check_txn(1 - winner);
        @(posedge clk); #1;
        check("ack_one_cycle", {31'b0, p0_ack | p1_ack}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        for (int p = 0; p < 2; p++) begin
            size_q[p]  = 2'b00;
            addr_q[p]  = 32'd0;
            wdata_q[p] = 32'd0;
        end
        for (int i = 0; i < RAM_N; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_oe_we", {29'b0, mem_cs, mem_oe, mem_we}, 32'd0);
        check("rst_acks", {30'b0, p1_ack, p0_ack}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'd0);
        check("rst_p1_rdata", p1_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tie straight out of reset: p0 first, then p1; a second tie goes to p0 again.
        run_pair(1'b0, 2'b10, 32'h40, 32'd0, 1'b0, 2'b10, 32'h80, 32'd0);
        run_pair(1'b0, 2'b10, 32'h44, 32'd0, 1'b0, 2'b10, 32'h84, 32'd0);

        run_single(0, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF);
        run_single(1, 1'b0, 2'b10, 32'h100, 32'd0);
        check("readback_deadbeef", p1_rdata, 32'hDEADBEEF);

        run_single(1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'd0);
        run_single(0, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_005A);
        run_single(1, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'd0);

        // Reset during the second beat of a word write.
        @(negedge clk);
        load_port(0, 1'b1, 2'b10, 32'h200, 32'h1122_3344);
        @(posedge clk); #1;
        check("rst_mid_beat0_cs", {31'b0, mem_cs}, 32'd1);
        @(posedge clk); #1;
        ref_mem[10'h200] = 8'h44;
        check("rst_mid_beat1_addr", mem_addr, 32'h201);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_bus", {29'b0, mem_cs, mem_oe, mem_we}, 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        check("rst_mid_ack", {30'b0, p1_ack, p0_ack}, 32'd0);
        req[0] = 1'b0;
        ref_last = 1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_idle", {28'b0, p1_ack, p0_ack, mem_cs, mem_we}, 32'd0);
        end
        run_single(0, 1'b0, 2'b10, 32'h200, 32'd0);

        // Randomized mix of single requests and ties over a small address window.
        for (int t = 0; t < 40; t++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                            : 32'($urandom_range(0, 48));
            if ($urandom_range(0, 2) == 0) begin
                run_pair(1'($urandom), 2'($urandom), a, $urandom,
                         1'($urandom), 2'($urandom), a + 32'($urandom_range(0, 4)), $urandom);
            end else begin
                run_single(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), a, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
